sd_spi_byte_shifter: RTL

//  SPI mode-0 byte transceiver for the SD card path. It sits directly downstream of the SD clock divider.
//  The divided clock (slow ~390 kHz during init, fast 25 MHz afterwards) is sampled on CLKin and edge-detected.
//  On each Start, the block shifts one byte out on SD_MOSI and one byte in from SD_MISO.
//  The SD command/init state machine above drives Start/TxByte and reads RxByte on the Done pulse.

---
 rtl/sd_spi_byte_shifter.sv | 115 +++++++++++
 1 files changed

// File: rtl/sd_spi_byte_shifter.sv
// SPI mode-0 byte transceiver for the SD card path. The divided SD clock is
// edge-detected in the CLKin domain; one byte is exchanged per accepted Start.
module sd_spi_byte_shifter #(
  parameter int   DATA_W    = 8,
  parameter logic MOSI_IDLE = 1'b1
) (
  input  logic              CLKin,
  input  logic              Reset,
  input  logic              SCKdiv,
  input  logic              Start,
  input  logic [DATA_W-1:0] TxByte,
  output logic              Busy,
  output logic              Done,
  output logic [DATA_W-1:0] RxByte,
  output logic              SD_SCK,
  output logic              SD_MOSI,
  input  logic              SD_MISO
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {IDLE, ALIGN, SHIFT, DONE} state_t;

  state_t              state_reg, state_next;
  logic                sckd_reg;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [DATA_W-1:0]   txsr_reg, txsr_next;
  logic [DATA_W-1:0]   rxsr_reg, rxsr_next;
  logic [DATA_W-1:0]   rxbyte_reg, rxbyte_next;
  logic                sck_reg, sck_next;
  logic                mosi_reg, mosi_next;
  logic                rise, fall;

  assign rise = SCKdiv & ~sckd_reg;
  assign fall = ~SCKdiv & sckd_reg;

  always_ff @(posedge CLKin or negedge Reset) begin
    if (!Reset) begin
      state_reg  <= IDLE;
      sckd_reg   <= 1'b0;
      cnt_reg    <= '0;
      txsr_reg   <= '0;
      rxsr_reg   <= '0;
      rxbyte_reg <= '0;
      sck_reg    <= 1'b0;
      mosi_reg   <= MOSI_IDLE;
    end else begin
      state_reg  <= state_next;
      sckd_reg   <= SCKdiv;
      cnt_reg    <= cnt_next;
      txsr_reg   <= txsr_next;
      rxsr_reg   <= rxsr_next;
      rxbyte_reg <= rxbyte_next;
      sck_reg    <= sck_next;
      mosi_reg   <= mosi_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    txsr_next   = txsr_reg;
    rxsr_next   = rxsr_reg;
    rxbyte_next = rxbyte_reg;
    sck_next    = 1'b0;
    mosi_next   = mosi_reg;
    case (state_reg)
      IDLE, DONE: begin
        mosi_next = MOSI_IDLE;
        // DONE accepts Start too, so transfers can run back to back
        if (Start) begin
          txsr_next  = TxByte;
          cnt_next   = CNT_W'(DATA_W);
          state_next = ALIGN;
        end else begin
          state_next = IDLE;
        end
      end
      ALIGN: begin
        // Waiting for a fall guarantees the first bit a full low half-period
        if (fall) begin
          mosi_next  = txsr_reg[DATA_W-1];
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sck_next = SCKdiv;
        if (rise) begin
          rxsr_next = {rxsr_reg[DATA_W-2:0], SD_MISO};
          cnt_next  = cnt_reg - 1'b1;
        end
        if (fall) begin
          if (cnt_reg != '0) begin
            txsr_next = txsr_reg << 1;
            mosi_next = txsr_reg[DATA_W-2];
          end else begin
            // Load RxByte here so it is already valid during the Done cycle
            sck_next    = 1'b0;
            mosi_next   = MOSI_IDLE;
            rxbyte_next = rxsr_reg;
            state_next  = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign Busy    = (state_reg == ALIGN) || (state_reg == SHIFT);
  assign Done    = (state_reg == DONE);
  assign RxByte  = rxbyte_reg;
  assign SD_SCK  = sck_reg;
  assign SD_MOSI = mosi_reg;

endmodule
